uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial UART receiver that consumes the 16x oversampling enable `ce_16` from the baud rate generator.
- Recovers LSB-first asynchronous frames: 1 start bit, DATA_BITS data bits, no parity, 1 stop bit.
- Presents each received word on a valid/ready holding register to the bus-side logic, with framing and overrun error pulses.

Parameters:
DATA_BITS, 8, data bits per frame (legal 5..9); sets rx_data width.
SYNC_STAGES, 2, flip-flop stages on ser_in before any use (legal >= 2).

Ports:
clock  input  1  system clock.
reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
ce_16  input  1  one-clock-wide enable at 16x baud, from the baud generator.
ser_in  input  1  asynchronous serial line, idle high.
rx_data  output  DATA_BITS  last accepted word; valid while rx_valid=1.
rx_valid  output  1  word available; held until consumed.
rx_ready  input  1  consumer accepts the word when rx_valid & rx_ready on a clock edge.
frame_err  output  1  one-clock pulse: stop bit sampled low.
overrun_err  output  1  one-clock pulse: a new word overwrote an unconsumed word.
busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset_n=0, async):
  - Outputs: rx_data=0, rx_valid=0, frame_err=0, overrun_err=0, busy=0.
  - Internal: FSM=IDLE, synchronizer chain=all 1s, tick counter=0, shift register=0.
- Synchronizer: ser_in passes through SYNC_STAGES flops; the result is `rxs`. All decisions use `rxs` only.
- Timing base:
  - FSM and counters advance only on clocks where ce_16=1. Clocks with ce_16=0 hold all state, except the output handshake.
  - 4-bit tick counter `tcnt` runs 0..15 within each bit period and wraps 15->0.
- Majority sampling:
  - Sample `rxs` at tcnt=7, 8 and 9.
  - The bit value is the majority of the 3 samples, resolved on the ce_16 tick where tcnt=9.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a ce_16 tick with rxs=0, go to START with tcnt=1 (that tick counts as tcnt=0). Otherwise stay.
  - START: at tcnt=9, if the majority is 1 (false start) go to IDLE and clear tcnt. Otherwise continue. At tcnt=15, go to DATA with bit index=0 and tcnt=0.
  - DATA: at tcnt=9, shift the majority value in LSB-first. At tcnt=15, if bit index=DATA_BITS-1 go to STOP; else increment the bit index. tcnt wraps to 0.
  - STOP: at tcnt=9, resolve the stop bit and go to IDLE with tcnt=0. Leaving early leaves 6 ticks of margin to catch the next start edge.
- Stop bit resolved 1 (good frame):
  - On the next clock edge: rx_data <= shift register, rx_valid <= 1.
  - If rx_valid was already 1 and is not being consumed that same clock, overrun_err pulses for 1 clock.
  - If consume and load coincide, the new word loads, rx_valid stays 1 and there is no overrun.
- Stop bit resolved 0 (bad frame):
  - frame_err pulses for 1 clock. The word is discarded; rx_data and rx_valid are unchanged.
- Latency: rx_valid rises on the clock edge following the ce_16 tick of stop-bit tcnt=9.
- Handshake:
  - On a clock with rx_valid & rx_ready and no load, rx_valid drops on that clock edge.
  - rx_ready has no effect while rx_valid=0.
- busy = (FSM != IDLE). It is registered with the FSM, so it has no extra latency.
- Line held low continuously:
  - Produces one frame with frame_err, then returns to IDLE.
  - Immediately re-enters START on the next tick (rxs=0), giving a repeated frame_err cadence. This is accepted behaviour.
- Reset mid-frame: all state clears at once. The next falling edge after reset release starts a fresh frame.

Test Plan:
- Send 8N1 byte 0xA5 at ce_16 every 4 clocks, rx_ready=1 -> one rx_valid with rx_data=0xA5; no frame_err or overrun_err; busy=0 after the stop sample.
- Drive ser_in low for 5 ce_16 ticks then high -> START aborted at tcnt=9; no rx_valid and no frame_err; busy returns to 0.
- Send 0x3C with the stop bit driven 0 -> frame_err pulses exactly 1 clock; rx_valid stays 0; rx_data keeps its previous value.
- Send 0x11 then 0x22 back-to-back with rx_ready=0 -> overrun_err pulses once at the second load; rx_data=0x22; rx_valid=1 until rx_ready=1, then drops the next clock.
- Inject a 1-tick glitch at tcnt=8 of data bit 3 while sending 0x00 -> rx_data=0x00 (majority rejects the glitch).
- Assert reset_n=0 during data bit 4 of 0xFF, release, then send 0x5A -> rx_data=0x5A; no spurious valid or frame_err from the aborted frame.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 16x-oversampled UART receiver (start, DATA_BITS data LSB-first,
//               stop) with majority voting and a valid/ready holding register.
// Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 ce_16,
    input  logic                 ser_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int c_IDX_W = $clog2(DATA_BITS);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                 r_state, w_state_nx;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxs;
    logic [3:0]             r_tcnt, w_tcnt_nx;
    logic [c_IDX_W-1:0]     r_idx, w_idx_nx;
    logic [DATA_BITS-1:0]   r_shift, w_shift_nx;
    logic                   r_s7, r_s8, w_maj;
    logic                   w_stop_good, w_stop_bad;
    logic                   r_load_good, r_load_bad;

    assign w_rxs = r_sync[SYNC_STAGES-1];
    assign w_maj = (r_s7 & r_s8) | (r_s7 & w_rxs) | (r_s8 & w_rxs);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '1;
            r_s7   <= 1'b1;
            r_s8   <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ser_in};
            // The third vote is taken live from w_rxs on the tcnt=9 tick.
            if (ce_16 && r_tcnt == 4'd7) r_s7 <= w_rxs;
            if (ce_16 && r_tcnt == 4'd8) r_s8 <= w_rxs;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_tcnt_nx   = r_tcnt;
        w_idx_nx    = r_idx;
        w_shift_nx  = r_shift;
        w_stop_good = 1'b0;
        w_stop_bad  = 1'b0;
        if (ce_16) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        w_state_nx = S_START;
                        w_tcnt_nx  = 4'd1;
                    end
                end
                S_START: begin
                    w_tcnt_nx = r_tcnt + 4'd1;
                    if (r_tcnt == 4'd9 && w_maj) begin
                        w_state_nx = S_IDLE;
                        w_tcnt_nx  = 4'd0;
                    end else if (r_tcnt == 4'd15) begin
                        w_state_nx = S_DATA;
                        w_idx_nx   = '0;
                    end
                end
                S_DATA: begin
                    w_tcnt_nx = r_tcnt + 4'd1;
                    if (r_tcnt == 4'd9) w_shift_nx = {w_maj, r_shift[DATA_BITS-1:1]};
                    if (r_tcnt == 4'd15) begin
                        if (r_idx == c_LAST_IDX) w_state_nx = S_STOP;
                        else                     w_idx_nx   = r_idx + 1'b1;
                    end
                end
                S_STOP: begin
                    w_tcnt_nx = r_tcnt + 4'd1;
                    if (r_tcnt == 4'd9) begin
                        w_state_nx  = S_IDLE;
                        w_tcnt_nx   = 4'd0;
                        w_stop_good = w_maj;
                        w_stop_bad  = ~w_maj;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_tcnt_nx  = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_tcnt      <= 4'd0;
            r_idx       <= '0;
            r_shift     <= '0;
            busy        <= 1'b0;
            r_load_good <= 1'b0;
            r_load_bad  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_tcnt      <= w_tcnt_nx;
            r_idx       <= w_idx_nx;
            r_shift     <= w_shift_nx;
            busy        <= (w_state_nx != S_IDLE);
            r_load_good <= w_stop_good;
            r_load_bad  <= w_stop_bad;
        end
    end

    // Holding register: a load always wins over a simultaneous consume.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= r_load_bad;
            overrun_err <= r_load_good & rx_valid & ~rx_ready;
            if (r_load_good) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
